// File: rtl/qspi_ram_reader.sv
// qspi_ram_reader: quad-SPI fast-read (0x0B) burst initiator for the external serial RAM.
// Every nibble spends one clk_in cycle with ram_clk low, then one with ram_clk high.
module qspi_ram_reader #(
  parameter logic [7:0] CMD          = 8'h0B,
  parameter int         DUMMY        = 6,
  parameter int         LEN_W        = 8,
  parameter int         CS_HIGH_CLKS = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [23:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  output logic             data_valid,
  output logic [7:0]       data_byte,
  output logic             data_last,
  output logic             busy,
  output logic             ram_clk,
  output logic             ram_cs_n,
  output logic [3:0]       ram_io_o,
  output logic             ram_io_oe,
  input  logic [3:0]       ram_io_i
);

  typedef enum logic [1:0] {IDLE, XFER, CSH} state_t;

  localparam logic [4:0]       DATA_K   = 5'(8 + DUMMY);
  localparam int               CSH_W    = $clog2(CS_HIGH_CLKS + 1);
  localparam logic [CSH_W-1:0] CSH_LAST = CSH_W'(CS_HIGH_CLKS - 1);

  state_t           state, state_nx;
  logic [4:0]       nib, nib_nx, nib_inc;
  logic             phase, phase_nx;
  logic             odd, odd_nx;
  logic             done, done_nx;
  logic [LEN_W-1:0] byte_cnt, byte_cnt_nx;
  logic [LEN_W-1:0] len_q, len_nx;
  logic [23:0]      addr_q, addr_nx;
  logic [3:0]       hi_nib, hi_nx;
  logic [CSH_W-1:0] csh_cnt, csh_cnt_nx;
  logic             clk_nx, cs_nx, oe_nx, valid_nx, last_nx;
  logic [3:0]       io_nx, nib_out;
  logic [7:0]       byte_nx;

  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign nib_inc   = nib + 5'd1;

  // Outgoing nibble for the next command/address slot; zero once dummy starts.
  always_comb begin
    nib_out = 4'h0;
    case (nib_inc)
      5'd1:    nib_out = CMD[3:0];
      5'd2:    nib_out = addr_q[23:20];
      5'd3:    nib_out = addr_q[19:16];
      5'd4:    nib_out = addr_q[15:12];
      5'd5:    nib_out = addr_q[11:8];
      5'd6:    nib_out = addr_q[7:4];
      5'd7:    nib_out = addr_q[3:0];
      default: nib_out = 4'h0;
    endcase
  end

  always_comb begin
    state_nx    = state;
    nib_nx      = nib;
    phase_nx    = phase;
    odd_nx      = odd;
    done_nx     = done;
    byte_cnt_nx = byte_cnt;
    len_nx      = len_q;
    addr_nx     = addr_q;
    hi_nx       = hi_nib;
    csh_cnt_nx  = csh_cnt;
    clk_nx      = ram_clk;
    cs_nx       = ram_cs_n;
    oe_nx       = ram_io_oe;
    io_nx       = ram_io_o;
    byte_nx     = data_byte;
    valid_nx    = 1'b0;
    last_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nx    = XFER;
          nib_nx      = 5'd0;
          phase_nx    = 1'b0;
          odd_nx      = 1'b0;
          done_nx     = 1'b0;
          byte_cnt_nx = '0;
          addr_nx     = req_addr;
          len_nx      = req_len;
          clk_nx      = 1'b0;
          cs_nx       = 1'b0;
          oe_nx       = 1'b1;
          io_nx       = CMD[7:4];
        end
      end
      XFER: begin
        if (!phase) begin
          // Rising ram_clk edge: the RAM has held this nibble for a full cycle.
          clk_nx   = 1'b1;
          phase_nx = 1'b1;
          if (nib == DATA_K) begin
            if (!odd) begin
              hi_nx = ram_io_i;
            end else begin
              valid_nx = 1'b1;
              byte_nx  = {hi_nib, ram_io_i};
              if (byte_cnt == len_q) begin
                last_nx = 1'b1;
                done_nx = 1'b1;
              end else begin
                byte_cnt_nx = byte_cnt + LEN_W'(1);
              end
            end
          end
        end else begin
          clk_nx   = 1'b0;
          phase_nx = 1'b0;
          if (done) begin
            state_nx   = CSH;
            cs_nx      = 1'b1;
            oe_nx      = 1'b0;
            io_nx      = 4'h0;
            csh_cnt_nx = '0;
          end else if (nib == DATA_K) begin
            odd_nx = !odd;
          end else begin
            nib_nx = nib_inc;
            oe_nx  = (nib_inc < 5'd8);
            io_nx  = nib_out;
          end
        end
      end
      CSH: begin
        if (csh_cnt == CSH_LAST) begin
          state_nx = IDLE;
        end else begin
          csh_cnt_nx = csh_cnt + CSH_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      nib        <= 5'd0;
      phase      <= 1'b0;
      odd        <= 1'b0;
      done       <= 1'b0;
      byte_cnt   <= '0;
      len_q      <= '0;
      addr_q     <= 24'h0;
      hi_nib     <= 4'h0;
      csh_cnt    <= '0;
      ram_clk    <= 1'b0;
      ram_cs_n   <= 1'b1;
      ram_io_oe  <= 1'b0;
      ram_io_o   <= 4'h0;
      data_valid <= 1'b0;
      data_byte  <= 8'h00;
      data_last  <= 1'b0;
    end else begin
      state      <= state_nx;
      nib        <= nib_nx;
      phase      <= phase_nx;
      odd        <= odd_nx;
      done       <= done_nx;
      byte_cnt   <= byte_cnt_nx;
      len_q      <= len_nx;
      addr_q     <= addr_nx;
      hi_nib     <= hi_nx;
      csh_cnt    <= csh_cnt_nx;
      ram_clk    <= clk_nx;
      ram_cs_n   <= cs_nx;
      ram_io_oe  <= oe_nx;
      ram_io_o   <= io_nx;
      data_valid <= valid_nx;
      data_byte  <= byte_nx;
      data_last  <= last_nx;
    end
  end

endmodule

// File: tb/tb_qspi_ram_reader.sv
// Bench for qspi_ram_reader: two instances (DUMMY=6 and DUMMY=10) with nibble-counting
// RAM responders that drive 0,1,2,... from the first data nibble onwards.
module tb_qspi_ram_reader;

  typedef struct {
    logic [7:0] byte_v;
    logic       last;
    int         edge_n;
  } exp_t;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    int          cs_edge;
    int          ready_edge;
  } vec_t;

  logic clk_in = 1'b0;
  logic rst;
  always #5 clk_in = ~clk_in;

  logic        req_valid_a, req_ready_a, data_valid_a, data_last_a, busy_a;
  logic [23:0] req_addr_a;
  logic [7:0]  req_len_a, data_byte_a;
  logic        ram_clk_a, ram_cs_n_a, ram_io_oe_a;
  logic [3:0]  ram_io_o_a, ram_io_i_a;

  logic        req_valid_b, req_ready_b, data_valid_b, data_last_b, busy_b;
  logic [23:0] req_addr_b;
  logic [7:0]  req_len_b, data_byte_b;
  logic        ram_clk_b, ram_cs_n_b, ram_io_oe_b;
  logic [3:0]  ram_io_o_b, ram_io_i_b;

  qspi_ram_reader dut_a (
    .clk_in(clk_in), .rst(rst),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_addr(req_addr_a), .req_len(req_len_a),
    .data_valid(data_valid_a), .data_byte(data_byte_a), .data_last(data_last_a),
    .busy(busy_a), .ram_clk(ram_clk_a), .ram_cs_n(ram_cs_n_a),
    .ram_io_o(ram_io_o_a), .ram_io_oe(ram_io_oe_a), .ram_io_i(ram_io_i_a)
  );

  qspi_ram_reader #(.DUMMY(10)) dut_b (
    .clk_in(clk_in), .rst(rst),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .req_len(req_len_b),
    .data_valid(data_valid_b), .data_byte(data_byte_b), .data_last(data_last_b),
    .busy(busy_b), .ram_clk(ram_clk_b), .ram_cs_n(ram_cs_n_b),
    .ram_io_o(ram_io_o_b), .ram_io_oe(ram_io_oe_b), .ram_io_i(ram_io_i_b)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int e0_a = 0, e0_b = 0, acc_a = 0, acc_b = 0;
  int dv_a = 0, dv_b = 0, toggles_b = 0;
  int fall_a = 0, fall_b = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[4];

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_nib(input int k, input logic [23:0] a);
    if (k == 0) return 4'h0;
    if (k == 1) return 4'hB;
    return a[4*(7-k) +: 4];
  endfunction

  // Edge counter and accept tracker; En = cyc - e0 when read on the following negedge.
  always @(posedge clk_in) begin
    cyc = cyc + 1;
    if (req_valid_a && req_ready_a) begin
      acc_a++;
      e0_a = cyc;
    end
    if (req_valid_b && req_ready_b) begin
      acc_b++;
      e0_b = cyc;
      toggles_b = 0;
    end
  end

  always @(ram_clk_b) toggles_b++;

  // RAM models: drive on the falling ram_clk edge, nibble index = falls since CS low.
  always @(negedge ram_cs_n_a) fall_a = 0;
  always @(negedge ram_clk_a) begin
    fall_a = fall_a + 1;
    ram_io_i_a = (fall_a >= 14) ? 4'(fall_a - 14) : 4'hA;
  end
  always @(negedge ram_cs_n_b) fall_b = 0;
  always @(negedge ram_clk_b) begin
    fall_b = fall_b + 1;
    ram_io_i_b = (fall_b >= 18) ? 4'(fall_b - 18) : 4'hA;
  end

  always @(negedge clk_in) begin : mon_a
    exp_t e;
    if (data_valid_a) begin
      dv_a++;
      if (q_a.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL a unexpected byte: got %0h at E%0d, wanted none", data_byte_a, cyc - e0_a);
      end else begin
        e = q_a.pop_front();
        check_output("a data_byte", data_byte_a, e.byte_v);
        check_output("a data_last", data_last_a, e.last);
        check_output("a byte edge", cyc - e0_a, e.edge_n);
      end
    end
  end

  always @(negedge clk_in) begin : mon_b
    exp_t e;
    if (data_valid_b) begin
      dv_b++;
      if (q_b.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL b unexpected byte: got %0h at E%0d, wanted none", data_byte_b, cyc - e0_b);
      end else begin
        e = q_b.pop_front();
        check_output("b data_byte", data_byte_b, e.byte_v);
        check_output("b data_last", data_last_b, e.last);
        check_output("b byte edge", cyc - e0_b, e.edge_n);
      end
    end
  end

  task automatic push_expected_a(input logic [7:0] len);
    for (int b = 0; b <= int'(len); b++)
      q_a.push_back('{{4'(2*b), 4'(2*b+1)}, (b == int'(len)), 31 + 4*b});
  endtask

  // Waits for ready, presents one request for a single cycle, returns #1 after E0.
  task automatic apply_stimulus(input logic [23:0] addr, input logic [7:0] len);
    int n = 0;
    while (!req_ready_a && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check_output("a ready before request", req_ready_a, 1);
    req_addr_a  = addr;
    req_len_a   = len;
    req_valid_a = 1'b1;
    push_expected_a(len);
    @(posedge clk_in);
    #1 req_valid_a = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    int n;
    int cs_rise = -1;
    int rdy_rise = -1;
    apply_stimulus(v.addr, v.len);
    for (int i = 0; i < 400 && rdy_rise < 0; i++) begin
      @(negedge clk_in);
      n = cyc - e0_a;
      if (n == 0) begin
        check_output("a cs_n after accept", ram_cs_n_a, 0);
        check_output("a busy after accept", busy_a, 1);
        check_output("a ready after accept", req_ready_a, 0);
      end
      if (n == 1) check_output("a ram_clk high phase", ram_clk_a, 1);
      if (n <= 14 && n % 2 == 0) begin
        check_output($sformatf("a io_o k=%0d", n/2), ram_io_o_a, exp_nib(n/2, v.addr));
        check_output($sformatf("a oe k=%0d", n/2), ram_io_oe_a, 1);
      end
      if (n == 16) begin
        check_output("a oe at dummy", ram_io_oe_a, 0);
        check_output("a io_o at dummy", ram_io_o_a, 0);
      end
      if (cs_rise < 0 && ram_cs_n_a) cs_rise = n;
      if (rdy_rise < 0 && req_ready_a) rdy_rise = n;
    end
    check_output("a cs_n rise edge", cs_rise, v.cs_edge);
    check_output("a ready rise edge", rdy_rise, v.ready_edge);
    check_output("a bytes left", q_a.size(), 0);
  endtask

  initial begin
    int first_e0, acc_snap, cs_high, dv_snap, n;
    vecs[0] = '{24'h123456, 8'd0, 32, 36};
    vecs[1] = '{24'h123456, 8'd3, 44, 48};
    vecs[2] = '{24'hABCDEF, 8'd7, 60, 64};
    vecs[3] = '{24'h000000, 8'd1, 36, 40};

    rst = 1'b1;
    req_valid_a = 1'b0; req_addr_a = 24'h0; req_len_a = 8'h0; ram_io_i_a = 4'h0;
    req_valid_b = 1'b0; req_addr_b = 24'h0; req_len_b = 8'h0; ram_io_i_b = 4'h0;
    repeat (3) @(negedge clk_in);
    check_output("reset cs_n", ram_cs_n_a, 1);
    check_output("reset ram_clk", ram_clk_a, 0);
    check_output("reset oe", ram_io_oe_a, 0);
    check_output("reset io_o", ram_io_o_a, 0);
    check_output("reset data_valid", data_valid_a, 0);
    check_output("reset data_last", data_last_a, 0);
    check_output("reset data_byte", data_byte_a, 0);
    check_output("reset busy", busy_a, 0);
    check_output("reset req_ready", req_ready_a, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vector(vecs[i]);

    // Back-to-back with req_valid held, then stray pulses while busy.
    @(negedge clk_in);
    req_addr_a = 24'h000100;
    req_len_a  = 8'd3;
    req_valid_a = 1'b1;
    push_expected_a(8'd3);
    push_expected_a(8'd3);
    @(posedge clk_in);
    #1 first_e0 = e0_a;
    acc_snap = acc_a;
    cs_high = 0;
    n = 0;
    while (acc_a == acc_snap && n < 200) begin
      @(negedge clk_in);
      if (acc_a == acc_snap && ram_cs_n_a) cs_high++;
      n++;
    end
    req_valid_a = 1'b0;
    check_output("b2b second accept edge", e0_a - first_e0, 49);
    check_output("b2b cs_n high >= 4", int'(cs_high >= 4), 1);
    acc_snap = acc_a;
    repeat (5) @(negedge clk_in);
    req_addr_a = 24'hFFFFFF;
    req_len_a  = 8'd0;
    req_valid_a = 1'b1;
    repeat (3) @(negedge clk_in);
    req_valid_a = 1'b0;
    n = 0;
    while (!req_ready_a && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    check_output("busy request ignored", acc_a, acc_snap);
    check_output("b2b bytes left", q_a.size(), 0);

    // Reset in the middle of DATA.
    apply_stimulus(24'h123456, 8'd3);
    n = 0;
    while (cyc - e0_a < 33 && n < 100) begin
      @(negedge clk_in);
      n++;
    end
    rst = 1'b1;
    dv_snap = dv_a;
    @(negedge clk_in);
    check_output("rst cs_n", ram_cs_n_a, 1);
    check_output("rst ram_clk", ram_clk_a, 0);
    check_output("rst oe", ram_io_oe_a, 0);
    q_a.delete();
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    #1 check_output("ready after rst", req_ready_a, 1);
    check_output("busy after rst", busy_a, 0);
    repeat (8) @(negedge clk_in);
    check_output("no bytes after rst", dv_a, dv_snap);

    // DUMMY=10 instance, 256-byte burst.
    @(negedge clk_in);
    req_addr_b = 24'h000000;
    req_len_b  = 8'd255;
    req_valid_b = 1'b1;
    for (int b = 0; b < 256; b++)
      q_b.push_back('{{4'(2*b), 4'(2*b+1)}, (b == 255), 39 + 4*b});
    dv_snap = dv_b;
    @(posedge clk_in);
    #1 req_valid_b = 1'b0;
    n = 0;
    while (!req_ready_b && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    check_output("b ready rise edge", cyc - e0_b, 1064);
    check_output("b byte count", dv_b - dv_snap, 256);
    check_output("b ram_clk toggles", toggles_b, 1060);
    check_output("b bytes left", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_ram_reader.md
# qspi_ram_reader

Quad-SPI burst read initiator for the external serial RAM, clocked from `clk_in`. It accepts a read request (start address and length), sends the fast-read command 0x0B with a 24-bit address on all four IO lines, runs the dummy phase, then returns the bytes that follow. It sits between the frame-buffer/LCD data path and the RAM pins. The top level owns the tristate pad buffers and connects `ram_io` to `ram_io_o`, `ram_io_oe` and `ram_io_i`.

## Interface
Parameters:
- `CMD`, 8'h0B: read command byte.
- `DUMMY`, 6: dummy nibble periods between the address and the data (1..15).
- `LEN_W`, 8: width of `req_len`.
- `CS_HIGH_CLKS`, 4: minimum number of `clk_in` cycles `ram_cs_n` stays high between bursts (≥2).

Ports:
- `clk_in`  in  1: system clock. One clock domain only.
- `rst`  in  1: reset. Synchronous, active-high.
- `req_valid`  in  1: request strobe.
- `req_ready`  out  1: the block can accept a request.
- `req_addr`  in  24: start byte address.
- `req_len`  in  LEN_W: burst length minus one; the burst is `req_len`+1 bytes.
- `data_valid`  out  1: one-cycle pulse per byte.
- `data_byte`  out  8: the byte; first nibble received is bits [7:4].
- `data_last`  out  1: high together with `data_valid` on the final byte.
- `busy`  out  1: high from request accept until `req_ready` rises again.
- `ram_clk`  out  1: serial clock, `clk_in`/2 while active, idles low.
- `ram_cs_n`  out  1: chip select, active low.
- `ram_io_o`  out  4: outgoing nibble.
- `ram_io_oe`  out  1: 1 means the block drives the IO lines.
- `ram_io_i`  in  4: incoming nibble.

## Operation
- **States:** IDLE → XFER (CMD, ADDR, DUMMY and DATA phases, tracked by a nibble counter) → CSH → IDLE.
- **Accept:** a request is accepted when `req_valid` & `req_ready`. `req_ready` = (state==IDLE) & !`rst`.
  - `req_addr` and `req_len` are latched on accept.
  - `req_valid` is ignored while busy.
- **Nibble stream, indexed k from 0, MSB first:**
  - k=0..1: `CMD`.
  - k=2..7: address bits [23:20] down to [3:0].
  - k=8..7+`DUMMY`: dummy.
  - k≥8+`DUMMY`: data nibbles.
- **Output enable:** `ram_io_oe`=1 for k<8 only. It drops at the start of the first dummy nibble and stays 0 through DATA and CSH. During dummy, `ram_io_o`=0.
- **Byte assembly:** data nibble j goes to the high half of the byte when j is even and the low half when j is odd. `data_valid` pulses after each odd j.
  - The byte counter stops after `req_len`+1 bytes.
  - Data arrives at a fixed rate. There is no backpressure and the consumer must accept every pulse.
- **End of burst:** after the last nibble is sampled:
  - `ram_clk` stays low and `ram_cs_n` goes to 1 (state CSH).
  - CSH lasts `CS_HIGH_CLKS` cycles, then the block returns to IDLE and `req_ready` becomes 1.
- **Reset:** `rst` forces IDLE from any state at the next edge. A transfer cut off by reset produces no further `data_valid`, and `ram_cs_n` is 1 after that edge.
- **Reset values:**
  - `ram_cs_n`=1.
  - 0: `ram_clk`, `ram_io_oe`, `ram_io_o`, `data_valid`, `data_last`, `data_byte`, `busy`.
  - `req_ready`=0 while `rst` is high.

## Timing
- Let E0 be the `clk_in` edge on which a request is accepted, and En the n-th edge after it.
- At E0:
  - `ram_cs_n`←0, `ram_clk`←0, `ram_io_oe`←1, `ram_io_o`←`CMD`[7:4].
  - `busy`←1, `req_ready`←0.
- Each nibble k uses two `clk_in` cycles:
  - Low phase from E(2k): `ram_clk`=0. Outputs change only at E(2k).
  - High phase from E(2k+1): `ram_clk`=1.
- The RAM samples on the rising edge of `ram_clk` and drives on the falling edge. The block samples `ram_io_i` at E(2k+1), the same edge on which `ram_clk` goes 1.
- **Byte timing:** byte b (from 0) is registered at E(19+2·`DUMMY`+4b). `data_valid` is high for exactly that one cycle. With `DUMMY`=6 the first byte appears at E31 and bytes follow every 4 cycles.
- **Burst length:** with N bytes, the last sample edge is E(2(7+`DUMMY`+2N)+1).
  - On the next edge `ram_cs_n`←1.
  - `CS_HIGH_CLKS` edges later, `req_ready`←1 and `busy`←0.
- The earliest accept of a new request is the edge after `req_ready` rises. This guarantees `ram_cs_n` stays high for ≥`CS_HIGH_CLKS` cycles between bursts.
- **Length wrap:** `req_len`=2^`LEN_W`−1 gives 2^`LEN_W` bytes (256 at the default). The burst length never wraps to zero.

## Test plan
- **Single-byte read:** `req_addr`=0x123456, `req_len`=0. Responder drives incrementing nibbles 0,1,… during DATA.
  - `ram_io_o` at E0,E2,…,E14 = 0,B,1,2,3,4,5,6.
  - `ram_io_oe` falls at E16.
  - One `data_valid` at E31 with `data_byte`=0x01 and `data_last`=1.
- **Four-byte burst:** `req_len`=3, same responder.
  - Bytes 0x01,0x23,0x45,0x67 at E31,E35,E39,E43.
  - `data_last` only with 0x67.
  - `ram_cs_n` rises at E44.
  - `req_ready` rises at E48.
- **Back-to-back requests:** `req_valid` held high across two requests.
  - Second accept occurs no earlier than E49.
  - `ram_cs_n` high for ≥4 cycles between bursts.
  - `req_valid` pulses while busy are ignored.
- **Reset mid-DATA:** assert `rst` at E33.
  - Next edge: `ram_cs_n`=1, `ram_clk`=0, `ram_io_oe`=0.
  - No `data_valid` after E33.
  - `req_ready`=1 on the first cycle after `rst` deasserts.
- **DUMMY=10, maximum length:** `DUMMY`=10, `req_len`=255.
  - First byte at E39.
  - 256 `data_valid` pulses at a 4-cycle pitch, `data_last` on the 256th.
  - `ram_clk` toggles exactly 2·(8+10+512) times per burst.
